// File: rtl/serial_digit_rx.sv
// rtl/serial_digit_rx.sv - 8N1 serial receiver decoding ASCII '0'-'9' and 'U' to a 4-bit code
module serial_digit_rx #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       sysclk,
  input  logic       rst,
  input  logic       rx,
  output logic [3:0] code,
  output logic [7:0] ascii,
  output logic       valid,
  output logic       bad_char,
  output logic       frame_err,
  output logic       busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          rx_m;
  logic          rx_s;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      code      <= '0;
      ascii     <= '0;
      valid     <= 1'b0;
      bad_char  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      valid     <= 1'b0;
      bad_char  <= 1'b0;
      frame_err <= 1'b0;
      cnt       <= cnt + 1'b1;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (!rx_s) state <= S_START;
        end
        S_START: begin
          if (cnt == HALF_M1) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_s ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          if (cnt == FULL_M1) begin
            cnt            <= '0;
            shift[bit_idx] <= rx_s;
            bit_idx        <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= S_STOP;
          end
        end
        S_STOP: begin
          if (cnt == FULL_M1) begin
            cnt <= '0;
            if (rx_s) begin
              ascii <= shift;
              state <= S_IDLE;
              if (shift >= 8'h30 && shift <= 8'h39) begin
                code  <= shift[3:0];
                valid <= 1'b1;
              end else if (shift == 8'h55) begin
                code  <= 4'hF;
                valid <= 1'b1;
              end else begin
                bad_char <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
              state     <= S_BREAK;
            end
          end
        end
        S_BREAK: begin
          // Hold off until the line returns high so a stuck-low line cannot retrigger.
          cnt <= '0;
          if (rx_s) state <= S_IDLE;
        end
        default: begin
          cnt   <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_serial_digit_rx.sv
// tb/tb_serial_digit_rx.sv - randomized self-checking bench for serial_digit_rx
module tb_serial_digit_rx;
  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;
  localparam int LAT  = 3 + HALF + 9 * CPB;
  localparam int K_VALID = 1;
  localparam int K_BAD   = 2;
  localparam int K_FERR  = 3;

  typedef struct {
    int         kind;
    int         cyc;
    logic [3:0] code;
    logic [7:0] ascii;
  } ev_t;

  logic       sysclk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic [3:0] code;
  logic [7:0] ascii;
  logic       valid;
  logic       bad_char;
  logic       frame_err;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int multi = 0;
  ev_t exp_q[$];
  ev_t got_q[$];
  logic [3:0] m_code = 4'h0;
  logic [7:0] m_ascii = 8'h00;

  serial_digit_rx #(.CLKS_PER_BIT(CPB)) dut (
    .sysclk(sysclk), .rst(rst), .rx(rx), .code(code), .ascii(ascii),
    .valid(valid), .bad_char(bad_char), .frame_err(frame_err), .busy(busy)
  );

  always #5 sysclk = ~sysclk;
  always @(posedge sysclk) cyc <= cyc + 1;

  always @(negedge sysclk) begin
    ev_t g;
    if (int'(valid) + int'(bad_char) + int'(frame_err) > 1) multi++;
    if (valid || bad_char || frame_err) begin
      g.kind  = valid ? K_VALID : (bad_char ? K_BAD : K_FERR);
      g.cyc   = cyc;
      g.code  = code;
      g.ascii = ascii;
      got_q.push_back(g);
    end
  end

  // Drives one frame starting just after a rising edge; the expected outcome is derived from the byte's character class.
  task automatic send_frame(input logic [7:0] b, input logic stop_ok);
    ev_t e;
    e.cyc = cyc + LAT;
    rx = 1'b0;
    repeat (CPB) @(posedge sysclk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(posedge sysclk);
      #1;
    end
    rx = stop_ok;
    if (!stop_ok) begin
      e.kind = K_FERR;
    end else begin
      m_ascii = b;
      if (b >= 8'h30 && b <= 8'h39) begin
        e.kind = K_VALID;
        m_code = 4'(b - 8'h30);
      end else if (b == 8'h55) begin
        e.kind = K_VALID;
        m_code = 4'hF;
      end else begin
        e.kind = K_BAD;
      end
    end
    e.code  = m_code;
    e.ascii = m_ascii;
    exp_q.push_back(e);
    repeat (CPB) @(posedge sysclk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(posedge sysclk);
    #1;
    checks++;
    if ({code, ascii, valid, bad_char, frame_err, busy} !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0000", {code, ascii, valid, bad_char, frame_err, busy});
    end
    rst = 1'b0;
    @(posedge sysclk);
    #1;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_single;
    ev_t e, g;
    send_frame(8'h37, 1'b1);
    repeat (5) @(posedge sysclk);
    #1;
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL single_count: got %0d expected %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      checks++;
      if (g.kind !== e.kind || g.cyc !== e.cyc) begin
        errors++;
        $display("FAIL single_pulse: got kind %0d cyc %0d expected kind %0d cyc %0d", g.kind, g.cyc, e.kind, e.cyc);
      end
      checks++;
      if (g.code !== e.code || g.ascii !== e.ascii) begin
        errors++;
        $display("FAIL single_data: got %h/%h expected %h/%h", g.code, g.ascii, e.code, e.ascii);
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL single_busy: got %b expected 0", busy);
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_back_to_back;
    ev_t e, g;
    send_frame(8'h30, 1'b1);
    send_frame(8'h39, 1'b1);
    send_frame(8'h55, 1'b1);
    repeat (5) @(posedge sysclk);
    #1;
    checks++;
    if (got_q.size() !== 3) begin
      errors++;
      $display("FAIL b2b_count: got %0d expected 3", got_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      checks++;
      if (g.kind !== e.kind || g.cyc !== e.cyc || g.code !== e.code || g.ascii !== e.ascii) begin
        errors++;
        $display("FAIL b2b_event: got %0d/%0d/%h/%h expected %0d/%0d/%h/%h",
                 g.kind, g.cyc, g.code, g.ascii, e.kind, e.cyc, e.code, e.ascii);
      end
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_bad_char;
    ev_t e, g;
    send_frame(8'h39, 1'b1);
    send_frame(8'h41, 1'b1);
    repeat (5) @(posedge sysclk);
    #1;
    checks++;
    if (got_q.size() !== 2) begin
      errors++;
      $display("FAIL bad_count: got %0d expected 2", got_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      checks++;
      if (g.kind !== e.kind || g.cyc !== e.cyc || g.code !== e.code || g.ascii !== e.ascii) begin
        errors++;
        $display("FAIL bad_event: got %0d/%0d/%h/%h expected %0d/%0d/%h/%h",
                 g.kind, g.cyc, g.code, g.ascii, e.kind, e.cyc, e.code, e.ascii);
      end
    end
    checks++;
    if (code !== 4'h9 || ascii !== 8'h41) begin
      errors++;
      $display("FAIL bad_hold: got %h/%h expected 9/41", code, ascii);
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_frame_err;
    ev_t e, g;
    send_frame(8'h35, 1'b0);
    repeat (20) @(posedge sysclk);
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL ferr_break_busy: got %b expected 1", busy);
    end
    repeat (20) @(posedge sysclk);
    #1;
    rx = 1'b1;
    repeat (10) @(posedge sysclk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL ferr_idle_busy: got %b expected 0", busy);
    end
    send_frame(8'h32, 1'b1);
    repeat (5) @(posedge sysclk);
    #1;
    checks++;
    if (got_q.size() !== 2) begin
      errors++;
      $display("FAIL ferr_count: got %0d expected 2", got_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      checks++;
      if (g.kind !== e.kind || g.cyc !== e.cyc || g.code !== e.code || g.ascii !== e.ascii) begin
        errors++;
        $display("FAIL ferr_event: got %0d/%0d/%h/%h expected %0d/%0d/%h/%h",
                 g.kind, g.cyc, g.code, g.ascii, e.kind, e.cyc, e.code, e.ascii);
      end
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_glitch;
    int busy_cnt;
    busy_cnt = 0;
    @(posedge sysclk);
    #1;
    rx = 1'b0;
    repeat (5) @(posedge sysclk);
    #1;
    rx = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge sysclk);
      if (busy) busy_cnt++;
    end
    checks++;
    if (busy_cnt < 1 || busy_cnt > HALF) begin
      errors++;
      $display("FAIL glitch_busy_cycles: got %0d expected 1..%0d", busy_cnt, HALF);
    end
    checks++;
    if (got_q.size() !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL glitch_quiet: got %0d events busy %b expected 0 events busy 0", got_q.size(), busy);
    end
    got_q.delete();
  endtask

  task automatic test_reset_midframe;
    ev_t e, g;
    logic [7:0] b;
    b = 8'h38;
    @(posedge sysclk);
    #1;
    rx = 1'b0;
    repeat (CPB) @(posedge sysclk);
    #1;
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      repeat (CPB) @(posedge sysclk);
      #1;
    end
    rx = b[4];
    repeat (CPB / 2) @(posedge sysclk);
    #1;
    rst = 1'b1;
    rx  = 1'b1;
    @(posedge sysclk);
    #1;
    checks++;
    if ({code, ascii, valid, bad_char, frame_err, busy} !== 16'h0) begin
      errors++;
      $display("FAIL midreset_outputs: got %h expected 0000", {code, ascii, valid, bad_char, frame_err, busy});
    end
    rst = 1'b0;
    m_code  = 4'h0;
    m_ascii = 8'h00;
    repeat (40) @(posedge sysclk);
    #1;
    checks++;
    if (got_q.size() !== 0) begin
      errors++;
      $display("FAIL midreset_quiet: got %0d events expected 0", got_q.size());
    end
    got_q.delete();
    send_frame(8'h33, 1'b1);
    repeat (5) @(posedge sysclk);
    #1;
    checks++;
    if (got_q.size() !== 1) begin
      errors++;
      $display("FAIL midreset_count: got %0d expected 1", got_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      checks++;
      if (g.kind !== e.kind || g.cyc !== e.cyc || g.code !== e.code || g.ascii !== e.ascii) begin
        errors++;
        $display("FAIL midreset_event: got %0d/%0d/%h/%h expected %0d/%0d/%h/%h",
                 g.kind, g.cyc, g.code, g.ascii, e.kind, e.cyc, e.code, e.ascii);
      end
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_random;
    ev_t e, g;
    logic [7:0] b;
    logic       ok;
    int         r, gap, n_exp;
    for (int n = 0; n < 24; n++) begin
      r = $urandom_range(0, 3);
      if (r == 0)      b = 8'($urandom);
      else if (r == 1) b = 8'h55;
      else             b = 8'(8'h30 + $urandom_range(0, 9));
      ok = ($urandom_range(0, 7) != 0);
      send_frame(b, ok);
      if (!ok) begin
        rx  = 1'b1;
        gap = $urandom_range(2, 6);
      end else begin
        gap = $urandom_range(0, 4);
      end
      for (int j = 0; j < gap; j++) begin
        @(posedge sysclk);
        #1;
      end
    end
    repeat (5) @(posedge sysclk);
    #1;
    n_exp = exp_q.size();
    checks++;
    if (got_q.size() !== n_exp) begin
      errors++;
      $display("FAIL rand_count: got %0d expected %0d", got_q.size(), n_exp);
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      checks++;
      if (g.kind !== e.kind || g.cyc !== e.cyc || g.code !== e.code || g.ascii !== e.ascii) begin
        errors++;
        $display("FAIL rand_event: got %0d/%0d/%h/%h expected %0d/%0d/%h/%h",
                 g.kind, g.cyc, g.code, g.ascii, e.kind, e.cyc, e.code, e.ascii);
      end
    end
    exp_q.delete();
    got_q.delete();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_bad_char();
    test_frame_err();
    test_glitch();
    test_reset_midframe();
    test_random();
    checks++;
    if (multi !== 0) begin
      errors++;
      $display("FAIL pulse_exclusive: got %0d overlapping cycles expected 0", multi);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_digit_rx.md
# serial_digit_rx

Serial receiver and character decoder at the far end of the keypad link. Recovers 8N1 frames (idle-high line, one low start bit, 8 data bits LSB first, one high stop bit) from the single-wire serial output of the keypad transmitter. Maps the ASCII characters '0'–'9' and 'U' back to the 4-bit switch code. Feeds the display/readout logic with a held code plus a one-cycle strobe, and flags malformed frames and unknown characters.

## Interface
- CLKS_PER_BIT, 5208, sysclk cycles per bit period (≥ 4); HALF = CLKS_PER_BIT/2, integer-truncated
- sysclk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- rx  in  1  asynchronous serial line, idle high
- code  out  4  last valid decoded code: '0'–'9' → 0–9, 'U' → 4'b1111
- ascii  out  8  last correctly framed byte, regardless of character
- valid  out  1  one-cycle pulse: code updated
- bad_char  out  1  one-cycle pulse: frame OK, byte not in {0x30–0x39, 0x55}
- frame_err  out  1  one-cycle pulse: stop bit sampled low
- busy  out  1  high in any state other than IDLE

## Operation
- Input synchroniser: rx passes through 2 flops (rx_s); reset value 1. All decisions use rx_s.
- States: IDLE, START, DATA, STOP, BREAK. A bit counter cnt (width ≥ clog2(CLKS_PER_BIT)) resets to 0 on every state entry and on every data-bit sample.
- IDLE: rx_s == 0 → START.
- START: at cnt == HALF-1, sample rx_s.
  - 0 → DATA, bit index 0.
  - 1 → IDLE (glitch rejected, no flag).
- DATA: at cnt == CLKS_PER_BIT-1, shift rx_s into shift[bit index] (LSB first) and increment the index. After index 7 is sampled → STOP.
- STOP: at cnt == CLKS_PER_BIT-1, sample rx_s.
  - 1 → load ascii ← shift, decode, → IDLE.
  - 0 → pulse frame_err, → BREAK; ascii and code unchanged.
- BREAK: wait for rx_s == 1, then → IDLE. This prevents a held-low line from re-triggering.
- Decode:
  - 0x30–0x39 → code ← byte[3:0], pulse valid.
  - 0x55 → code ← 4'b1111, pulse valid.
  - Any other byte → code unchanged, pulse bad_char.
  - 0x00 is treated as bad_char.
- At most one of valid / bad_char / frame_err is high in any cycle.

## Timing
- Reset: state IDLE, cnt 0, shift 0, code 0, ascii 0, valid 0, bad_char 0, frame_err 0, busy 0, synchroniser flops 1.
- Reset asserted mid-frame aborts the frame with no pulse. After reset is released, a frame is recognised only from a fresh falling edge.
- Start detect: IDLE sees rx_s low 2 cycles after the rx falling edge. START is entered the next cycle.
- Sample points relative to START entry:
  - Start bit: HALF-1.
  - Data bit k: HALF + (k+1)·CLKS_PER_BIT − 1.
  - Stop bit: HALF + 9·CLKS_PER_BIT − 1.
  - All samples land mid-bit, offset by the 2-cycle synchroniser latency.
- Outputs register the cycle after the stop sample: ascii/code load and the valid (or bad_char/frame_err) pulse are high for exactly 1 cycle.
- busy goes high the cycle after START entry and falls in the same cycle as the pulse.
- Back-to-back frames: a falling edge arriving immediately after the stop-bit sample point is detected normally. No idle gap beyond the stop bit is required.
- Tolerates ±4 % baud mismatch (cumulative drift < HALF at the stop sample).

## Test plan
All scenarios use CLKS_PER_BIT = 16, bits driven for exactly 16 cycles each.
- Frame 0x37 ('7') → valid pulse, code = 4'h7, ascii = 0x37, busy low afterwards; valid exactly 1 cycle, 1 cycle after the stop sample.
- Frames '0', '9', 'U' back-to-back with no idle gap → three valid pulses, code sequence 0, 9, 4'hF.
- Frame 0x41 ('A') → bad_char pulse, code keeps its prior value 4'h9, ascii = 0x41, valid stays low.
- Frame 0x35 with the stop bit driven low, line then held low 40 cycles → one frame_err pulse, no further activity until the line returns high; a following '2' frame decodes to code = 2.
- rx low pulse of 5 cycles (shorter than HALF) → no flags, state returns to IDLE, busy high only during START.
- rst asserted during data bit 4 of '8' → all outputs 0 the next cycle; a subsequent complete '3' frame yields code = 3.
